conv_via_tiling_mul_pipe: RTL and testbench
===========================================

Name: conv_via_tiling_mul_pipe

Overview:
Parametrised, pipelined successor to the combinational 32x32 tiling multiplier used in the conv_via_tiling datapath. It computes din0*din1 with per-transaction signed/unsigned operand mode, fixed-point scaling (right shift with optional rounding) and truncation to dout_WIDTH. It has a NUM_STAGE-deep register pipeline with a valid/ready handshake and full-pipeline backpressure. It sits between the tile operand buffers and the accumulator stage.

Parameters:
ID, 1, instance tag; no functional effect
NUM_STAGE, 3, pipeline latency in cycles; legal range 1..6
din0_WIDTH, 32, operand 0 width
din1_WIDTH, 32, operand 1 width
dout_WIDTH, 32, result width
SHIFT, 0, arithmetic right shift applied to the full product; 0..din0_WIDTH+din1_WIDTH-1
ROUND, 0, 1 = round-half-up before the shift (ignored when SHIFT=0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operands valid
in_ready  out  1  block accepts operands this cycle
din0  in  din0_WIDTH  operand 0
din1  in  din1_WIDTH  operand 1
mode  in  2  bit0 = din0 signed, bit1 = din1 signed; sampled with operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
dout  out  dout_WIDTH  scaled result
dout_sat  out  1  result was clipped (MUL_PIPE_SAT_EN only; otherwise tied 0)

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: all stage valid bits 0, all data registers 0. Outputs: out_valid=0, dout=0, dout_sat=0. in_ready=1 while reset is deasserted and the pipe is empty.
- Reset mid-operation: all in-flight results are discarded; no partial result appears after reset is released.
- Handshake:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall, combinational.
  - During a stall every stage register, including valid bits, holds its value. dout and out_valid stay stable until accepted.
  - Bubbles advance normally when not stalled. Internal stages are not compacted.
- Latency: a transfer accepted at cycle t with no stalls gives out_valid at t+NUM_STAGE. Throughput is 1 per cycle. Back-to-back results keep input order.
- Pipeline structure:
  - Stage 1 registers the operands after extension to din0_WIDTH+1 and din1_WIDTH+1 bits (sign- or zero-extended per mode).
  - The next stage forms the signed product P, width din0_WIDTH+din1_WIDTH+2.
  - The last stage registers the scaled result.
  - With NUM_STAGE=1, the product and scaling are computed combinationally from the stage-1 registers. Extra stages are pure delay registers placed after the product.
- Arithmetic:
  - If ROUND=1 and SHIFT>0, R = (P + 2^(SHIFT-1)) >>> SHIFT; otherwise R = P >>> SHIFT.
  - Without the macro, dout = R[dout_WIDTH-1:0] (wrap).
  - A mixed-sign mode (e.g. 01) treats only the flagged operand as two's complement.
- Simultaneous events: input accept and output accept in the same cycle are legal and sustain full rate. in_valid while stalled has no effect.

Optional Feature:
MUL_PIPE_SAT_EN:
- Defined: if R lies outside the representable range of dout, dout saturates. For signed results (any mode bit set) the limits are -2^(dout_WIDTH-1) and 2^(dout_WIDTH-1)-1. For unsigned results (mode 00) the limit is 2^dout_WIDTH-1. dout_sat=1 for that result, travelling with its valid bit.
- Undefined: dout wraps and dout_sat is constant 0.

Decomposition:
- Package conv_via_tiling_mul_pkg holds:
  - mode encodings MODE_UU=2'b00, MODE_SU=2'b01, MODE_US=2'b10, MODE_SS=2'b11;
  - function prod_width(w0, w1) returning w0+w1+2;
  - constant MAX_NUM_STAGE=6.
- One sub-module, conv_via_tiling_mul_round_sat: combinational round, shift and truncate/saturate of P. It is instantiated once before the final register.

Test Plan:
- Latency and reset: NUM_STAGE=3, mode=11, din0=-7, din1=6, out_ready=1 -> out_valid exactly 3 cycles after accept, dout=-42; out_valid=0 and dout=0 throughout reset.
- Mode: din0=32'hFFFFFFFF, din1=2 with mode 00 -> dout=32'hFFFFFFFE (wrap of 0x1FFFFFFFE); with mode 11 -> dout=-2; with mode 01 -> dout=-2.
- Rounding: SHIFT=4, ROUND=1, din0=24, din1=1 -> dout=2; with ROUND=0 -> dout=1; din0=-24, ROUND=1 -> dout=-1.
- Backpressure: stream 10 products k*k (k=1..10) with out_ready low on cycles 4-8 -> in_ready low during stall, no loss or duplication, outputs in order 1,4,...,100.
- Saturation (macro defined): dout_WIDTH=16, mode=11, din0=300, din1=300 -> dout=32767, dout_sat=1; din0=-300 -> dout=-32768, dout_sat=1; without the macro -> dout=16'h5F90, dout_sat=0.
- Mid-flight reset: assert reset while 3 results are in flight -> out_valid=0 immediately; after release, no stale result is emitted.

Source files
------------

// File: rtl/conv_via_tiling_mul_pkg.sv
// Shared constants for the pipelined tiling multiplier: operand-mode encodings,
// product width helper and the supported pipeline depth limit.
package conv_via_tiling_mul_pkg;

  localparam logic [1:0] MODE_UU = 2'b00;
  localparam logic [1:0] MODE_SU = 2'b01;
  localparam logic [1:0] MODE_US = 2'b10;
  localparam logic [1:0] MODE_SS = 2'b11;

  localparam int MAX_NUM_STAGE = 6;

  // Both operands are widened by one bit so mixed-sign products fit in a signed result.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

endpackage

// File: rtl/conv_via_tiling_mul_pipe_if.sv
// Operand/result bus of the pipelined tiling multiplier.
interface conv_via_tiling_mul_pipe_if #(
  parameter int DIN0_W = 32,
  parameter int DIN1_W = 32,
  parameter int DOUT_W = 32
) ();

  // Handshake: a beat moves when valid && ready on the same rising edge. in_ready
  // drops only while the result register is full and not taken (out_valid && !out_ready);
  // out_valid/dout/dout_sat then hold until accepted. Valid never waits on ready.
  logic              in_valid;
  logic              in_ready;
  logic [DIN0_W-1:0] din0;
  logic [DIN1_W-1:0] din1;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] dout;
  logic              dout_sat;

  modport master (
    output in_valid, din0, din1, mode, out_ready,
    input  in_ready, out_valid, dout, dout_sat
  );

  modport slave (
    input  in_valid, din0, din1, mode, out_ready,
    output in_ready, out_valid, dout, dout_sat
  );

endinterface

// File: rtl/conv_via_tiling_mul_round_sat.sv
// Round, arithmetic-shift and truncate the full product. With MUL_PIPE_SAT_EN
// defined the result clips to the dout range and flags it; otherwise it wraps.
module conv_via_tiling_mul_round_sat #(
  parameter int PW     = 66,
  parameter int DOUT_W = 32,
  parameter int SHIFT  = 0,
  parameter int ROUND  = 0
) (
  input  logic signed [PW-1:0]     i_p,
  input  logic                     i_signed,
  output logic        [DOUT_W-1:0] o_dout,
  output logic                     o_sat
);

  // One extra bit keeps the rounding addend from overflowing the product.
  localparam logic signed [PW:0] RND_ADD =
    (ROUND != 0 && SHIFT > 0) ? ((PW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  logic signed [PW:0] w_sum;
  logic signed [PW:0] w_r;

  assign w_sum = {i_p[PW-1], i_p} + RND_ADD;
  assign w_r   = w_sum >>> SHIFT;

`ifdef MUL_PIPE_SAT_EN
  logic w_fit_s;
  logic w_fit_u;

  assign w_fit_s = (w_r[PW:DOUT_W-1] == '0) || (w_r[PW:DOUT_W-1] == '1);
  assign w_fit_u = (w_r[PW:DOUT_W] == '0);

  always_comb begin
    o_dout = w_r[DOUT_W-1:0];
    o_sat  = 1'b0;
    if (i_signed && !w_fit_s) begin
      o_sat  = 1'b1;
      o_dout = w_r[PW] ? {1'b1, {(DOUT_W-1){1'b0}}} : {1'b0, {(DOUT_W-1){1'b1}}};
    end else if (!i_signed && !w_fit_u) begin
      o_sat  = 1'b1;
      o_dout = w_r[PW] ? '0 : '1;
    end
  end
`else
  logic [PW-DOUT_W:0] w_unused_hi;
  logic               w_unused_sgn;

  assign w_unused_hi  = w_r[PW:DOUT_W];
  assign w_unused_sgn = i_signed;
  assign o_dout       = w_r[DOUT_W-1:0];
  assign o_sat        = 1'b0;
`endif

endmodule

// File: rtl/conv_via_tiling_mul_pipe.sv
// NUM_STAGE-deep pipelined din0*din1 with per-beat signedness, scaling and
// whole-pipe backpressure. Optional clipping via MUL_PIPE_SAT_EN.
module conv_via_tiling_mul_pipe
  import conv_via_tiling_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0
) (
  input logic clk,
  input logic reset,
  conv_via_tiling_mul_pipe_if.slave bus
);

  localparam int PW        = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int unused_id = ID;

  logic                     w_stall;
  logic                     w_adv;
  logic [NUM_STAGE:1]       r_vld;
  logic signed [din0_WIDTH:0] r_a;
  logic signed [din1_WIDTH:0] r_b;
  logic                     r_sgn;
  logic signed [PW-1:0]     w_a_x;
  logic signed [PW-1:0]     w_b_x;
  logic signed [PW-1:0]     w_prod;
  logic signed [PW-1:0]     w_rs_p;
  logic                     w_rs_sgn;
  logic [dout_WIDTH-1:0]    w_rs_dout;
  logic                     w_rs_sat;

  // The whole pipe freezes while the last stage holds an unaccepted result.
  assign w_stall       = r_vld[NUM_STAGE] & ~bus.out_ready;
  assign w_adv         = ~w_stall;
  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = r_vld[NUM_STAGE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
    end else if (w_adv) begin
      r_vld[1] <= bus.in_valid;
      for (int i = 2; i <= NUM_STAGE; i++) r_vld[i] <= r_vld[i-1];
      r_a   <= {bus.mode[0] & bus.din0[din0_WIDTH-1], bus.din0};
      r_b   <= {bus.mode[1] & bus.din1[din1_WIDTH-1], bus.din1};
      r_sgn <= (bus.mode != MODE_UU);
    end
  end

  assign w_a_x  = {{(PW-din0_WIDTH-1){r_a[din0_WIDTH]}}, r_a};
  assign w_b_x  = {{(PW-din1_WIDTH-1){r_b[din1_WIDTH]}}, r_b};
  assign w_prod = w_a_x * w_b_x;

  generate
    if (NUM_STAGE >= 3) begin : g_pdly
      // Product register followed by pure delay stages up to the final register.
      logic signed [PW-1:0] r_p  [NUM_STAGE-2];
      logic                 r_ps [NUM_STAGE-2];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NUM_STAGE - 2; i++) begin
            r_p[i]  <= '0;
            r_ps[i] <= 1'b0;
          end
        end else if (w_adv) begin
          r_p[0]  <= w_prod;
          r_ps[0] <= r_sgn;
          for (int i = 1; i < NUM_STAGE - 2; i++) begin
            r_p[i]  <= r_p[i-1];
            r_ps[i] <= r_ps[i-1];
          end
        end
      end

      assign w_rs_p   = r_p[NUM_STAGE-3];
      assign w_rs_sgn = r_ps[NUM_STAGE-3];
    end else begin : g_pnone
      assign w_rs_p   = w_prod;
      assign w_rs_sgn = r_sgn;
    end
  endgenerate

  conv_via_tiling_mul_round_sat #(
    .PW     (PW),
    .DOUT_W (dout_WIDTH),
    .SHIFT  (SHIFT),
    .ROUND  (ROUND)
  ) u_round_sat (
    .i_p      (w_rs_p),
    .i_signed (w_rs_sgn),
    .o_dout   (w_rs_dout),
    .o_sat    (w_rs_sat)
  );

  generate
    if (NUM_STAGE == 1) begin : g_out_comb
      assign bus.dout     = w_rs_dout;
      assign bus.dout_sat = w_rs_sat;
    end else begin : g_out_reg
      logic [dout_WIDTH-1:0] r_dout;
      logic                  r_sat;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_dout <= '0;
          r_sat  <= 1'b0;
        end else if (w_adv) begin
          r_dout <= w_rs_dout;
          r_sat  <= w_rs_sat;
        end
      end

      assign bus.dout     = r_dout;
      assign bus.dout_sat = r_sat;
    end
  endgenerate

endmodule

// File: tb/tb_conv_via_tiling_mul_pipe.sv
// Bench for conv_via_tiling_mul_pipe: four differently configured instances share
// one stimulus stream; each is scored against an arithmetic model of its config.
module tb_conv_via_tiling_mul_pipe;
  import conv_via_tiling_mul_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] din0;
  logic [31:0] din1;
  logic [1:0]  mode;
  logic        out_ready;
  logic        capture;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_q [4][$];
  logic [31:0] got0 [$];
  logic        prev_stall [4];
  logic [31:0] prev_d [4];

  conv_via_tiling_mul_pipe_if #(.DIN0_W(32), .DIN1_W(32), .DOUT_W(32)) if0 ();
  conv_via_tiling_mul_pipe_if #(.DIN0_W(32), .DIN1_W(32), .DOUT_W(32)) if1 ();
  conv_via_tiling_mul_pipe_if #(.DIN0_W(32), .DIN1_W(32), .DOUT_W(32)) if2 ();
  conv_via_tiling_mul_pipe_if #(.DIN0_W(32), .DIN1_W(32), .DOUT_W(16)) if3 ();

  assign if0.in_valid = in_valid; assign if0.din0 = din0; assign if0.din1 = din1;
  assign if0.mode = mode; assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid; assign if1.din0 = din0; assign if1.din1 = din1;
  assign if1.mode = mode; assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid; assign if2.din0 = din0; assign if2.din1 = din1;
  assign if2.mode = mode; assign if2.out_ready = out_ready;
  assign if3.in_valid = in_valid; assign if3.din0 = din0; assign if3.din1 = din1;
  assign if3.mode = mode; assign if3.out_ready = out_ready;

  conv_via_tiling_mul_pipe #(.ID(0), .NUM_STAGE(3), .din0_WIDTH(32), .din1_WIDTH(32),
    .dout_WIDTH(32), .SHIFT(0), .ROUND(0)) u_dut0 (.clk(clk), .reset(rst), .bus(if0));
  conv_via_tiling_mul_pipe #(.ID(1), .NUM_STAGE(1), .din0_WIDTH(32), .din1_WIDTH(32),
    .dout_WIDTH(32), .SHIFT(4), .ROUND(1)) u_dut1 (.clk(clk), .reset(rst), .bus(if1));
  conv_via_tiling_mul_pipe #(.ID(2), .NUM_STAGE(2), .din0_WIDTH(32), .din1_WIDTH(32),
    .dout_WIDTH(32), .SHIFT(4), .ROUND(0)) u_dut2 (.clk(clk), .reset(rst), .bus(if2));
  conv_via_tiling_mul_pipe #(.ID(3), .NUM_STAGE(6), .din0_WIDTH(32), .din1_WIDTH(32),
    .dout_WIDTH(16), .SHIFT(0), .ROUND(0)) u_dut3 (.clk(clk), .reset(rst), .bus(if3));

  logic        ov [4];
  logic        ir [4];
  logic        sv [4];
  logic [31:0] dv [4];

  assign ov[0] = if0.out_valid; assign ir[0] = if0.in_ready; assign sv[0] = if0.dout_sat;
  assign ov[1] = if1.out_valid; assign ir[1] = if1.in_ready; assign sv[1] = if1.dout_sat;
  assign ov[2] = if2.out_valid; assign ir[2] = if2.in_ready; assign sv[2] = if2.dout_sat;
  assign ov[3] = if3.out_valid; assign ir[3] = if3.in_ready; assign sv[3] = if3.dout_sat;
  assign dv[0] = if0.dout; assign dv[1] = if1.dout; assign dv[2] = if2.dout;
  assign dv[3] = {16'h0, if3.dout};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish before 200000");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- model ----------------
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] m, input int sh, input bit rnd,
                                        input int w);
    logic signed [71:0] pa, pb, p, hi, lo;
    logic [31:0] mask, d;
    logic s;
    pa = {{40{m[0] & a[31]}}, a};
    pb = {{40{m[1] & b[31]}}, b};
    p  = pa * pb;
    if (rnd && sh > 0) p = p + (72'sd1 <<< (sh - 1));
    p    = p >>> sh;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    d    = p[31:0] & mask;
    s    = 1'b0;
`ifdef MUL_PIPE_SAT_EN
    if (m != MODE_UU) begin
      hi = (72'sd1 <<< (w - 1)) - 72'sd1;
      lo = -(72'sd1 <<< (w - 1));
    end else begin
      hi = (72'sd1 <<< w) - 72'sd1;
      lo = 72'sd0;
    end
    if (p > hi) begin d = hi[31:0] & mask; s = 1'b1; end
    else if (p < lo) begin d = lo[31:0] & mask; s = 1'b1; end
`else
    hi = 72'sd0;
    lo = 72'sd0;
`endif
    return {s, d};
  endfunction

  function automatic logic [32:0] model_k(input int k, input logic [31:0] a,
                                          input logic [31:0] b, input logic [1:0] m);
    case (k)
      0:       return model(a, b, m, 0, 1'b0, 32);
      1:       return model(a, b, m, 4, 1'b1, 32);
      2:       return model(a, b, m, 4, 1'b0, 32);
      default: return model(a, b, m, 0, 1'b0, 16);
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got %h, required %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare (negedge, away from active edge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) prev_stall[k] = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("in_ready", k, 64'(ir[k]), 64'(!(ov[k] && !out_ready)));
        if (prev_stall[k]) begin
          chk("hold_valid", k, 64'(ov[k]), 64'd1);
          chk("hold_dout", k, 64'(dv[k]), 64'(prev_d[k]));
        end
        if (in_valid && ir[k]) exp_q[k].push_back(model_k(k, din0, din1, mode));
        if (ov[k] && out_ready) begin
          chk("out_expected", k, 64'(exp_q[k].size() != 0), 64'd1);
          if (exp_q[k].size() != 0) chk("result", k, 64'({sv[k], dv[k]}), 64'(exp_q[k].pop_front()));
          if (k == 0 && capture) got0.push_back(dv[0]);
        end
        prev_stall[k] = ov[k] && !out_ready;
        prev_d[k]     = dv[k];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    mode     = m;
    @(negedge clk);
    while (!if0.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("send_timeout", 0, 64'(guard < 100), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc       = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int k = 0; k < 4; k++) chk("drain_empty", k, 64'(exp_q[k].size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 400));
      1:       return -32'($urandom_range(1, 400));
      2:       return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  logic [31:0] da [12];
  logic [31:0] db [12];
  logic [1:0]  dm [12];

  initial begin
    int cyc;
    rst = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0; mode = '0;
    out_ready = 1'b1; capture = 1'b0;
    #1 rst = 1'b1;

    repeat (3) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        chk("rst_valid", k, 64'(ov[k]), 64'd0);
        chk("rst_dout", k, 64'(dv[k]), 64'd0);
        chk("rst_sat", k, 64'(sv[k]), 64'd0);
      end
    end
    rst = 1'b0;

    // Literal expectations that pin the model.
    chk("m_ss", 0, 64'(model(32'hFFFF_FFF9, 32'd6, MODE_SS, 0, 1'b0, 32)), {31'd0, 1'b0, 32'hFFFF_FFD6});
    chk("m_uu", 0, 64'(model(32'hFFFF_FFFF, 32'd2, MODE_UU, 0, 1'b0, 32)), {31'd0, 1'b0, 32'hFFFF_FFFE});
    chk("m_ss2", 0, 64'(model(32'hFFFF_FFFF, 32'd2, MODE_SS, 0, 1'b0, 32)), {31'd0, 1'b0, 32'hFFFF_FFFE});
    chk("m_su", 0, 64'(model(32'hFFFF_FFFF, 32'd2, MODE_SU, 0, 1'b0, 32)), {31'd0, 1'b0, 32'hFFFF_FFFE});
    chk("m_rnd1", 1, 64'(model(32'd24, 32'd1, MODE_SS, 4, 1'b1, 32)), 64'd2);
    chk("m_rnd0", 2, 64'(model(32'd24, 32'd1, MODE_SS, 4, 1'b0, 32)), 64'd1);
    chk("m_rndn", 1, 64'(model(32'hFFFF_FFE8, 32'd1, MODE_SS, 4, 1'b1, 32)), {31'd0, 1'b0, 32'hFFFF_FFFF});
`ifdef MUL_PIPE_SAT_EN
    chk("m_satp", 3, 64'(model(32'd300, 32'd300, MODE_SS, 0, 1'b0, 16)), {31'd0, 1'b1, 32'h0000_7FFF});
    chk("m_satn", 3, 64'(model(32'hFFFF_FED4, 32'd300, MODE_SS, 0, 1'b0, 16)), {31'd0, 1'b1, 32'h0000_8000});
`else
    chk("m_wrapp", 3, 64'(model(32'd300, 32'd300, MODE_SS, 0, 1'b0, 16)), {31'd0, 1'b0, 32'h0000_5F90});
    chk("m_wrapn", 3, 64'(model(32'hFFFF_FED4, 32'd300, MODE_SS, 0, 1'b0, 16)), {31'd0, 1'b0, 32'h0000_A070});
`endif

    // Latency of the 3-stage instance.
    @(posedge clk);
    #1;
    in_valid = 1'b1; din0 = 32'hFFFF_FFF9; din1 = 32'd6; mode = MODE_SS;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!if0.out_valid && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 0, 64'(cyc), 64'd3);
    chk("lat_dout", 0, 64'(if0.dout), 64'hFFFF_FFD6);
    drain();

    // Directed operand/mode/rounding/saturation cases, back to back.
    da = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd24, 32'hFFFF_FFE8,
           32'd24, 32'd300, 32'hFFFF_FED4, 32'd300, 32'h8000_0000, 32'd0};
    db = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd300, 32'd300, 32'd300,
           32'h8000_0000, 32'hFFFF_FFFF};
    dm = '{MODE_UU, MODE_SS, MODE_SU, MODE_US, MODE_SS, MODE_SS, MODE_UU, MODE_SS, MODE_SS,
           MODE_UU, MODE_SS, MODE_SS};
    for (int i = 0; i < 12; i++) send(da[i], db[i], dm[i]);
    drain();

    // Backpressure: k*k stream with out_ready low on cycles 4..8.
    got0.delete();
    capture = 1'b1;
    fork
      begin
        for (int c = 1; c <= 25; c++) begin
          out_ready = !(c >= 4 && c <= 8);
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int k = 1; k <= 10; k++) send(32'(k), 32'(k), MODE_UU);
      end
    join
    drain();
    capture = 1'b0;
    chk("bp_count", 0, 64'(got0.size()), 64'd10);
    for (int k = 1; k <= 10; k++)
      if (got0.size() != 0) chk("bp_order", 0, 64'(got0.pop_front()), 64'(k * k));

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      din0      = rand_op();
      din1      = rand_op();
      mode      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 4) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with results in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; din0 = 32'(i + 2); din1 = 32'd3; mode = MODE_UU;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("midrst_valid", k, 64'(ov[k]), 64'd0);
      chk("midrst_dout", k, 64'(dv[k]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) chk("no_stale", k, 64'(ov[k]), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
